// File: rtl/vita_tx_flow_ctrl_pkg.sv
// vita_tx_flow_ctrl_pkg: context-word offsets, parser states and settings offsets
// shared by the flow-control endpoint and its context parser.
package vita_tx_flow_ctrl_pkg;

    localparam int SEQ_W = 12;

    localparam logic [2:0] W_HDR     = 3'd0;
    localparam logic [2:0] W_SID     = 3'd1;
    localparam logic [2:0] W_SECS    = 3'd2;
    localparam logic [2:0] W_FRAC_HI = 3'd3;
    localparam logic [2:0] W_FRAC_LO = 3'd4;
    localparam logic [2:0] W_MSG     = 3'd5;
    localparam logic [2:0] W_SEQ     = 3'd6;

    localparam logic [7:0] SR_WINDOW   = 8'd0;
    localparam logic [7:0] SR_STREAMID = 8'd1;
    localparam logic [7:0] SR_CLEAR    = 8'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_TRANS, S_HDR, S_SID, S_TIME, S_MSG, S_SEQ, S_DRAIN
    } ctx_state_t;

    // Parser state that handles the context word at offset idx.
    function automatic ctx_state_t word_state(input logic [2:0] idx);
        return idx == W_HDR ? S_HDR :
               idx == W_SID ? S_SID :
               (idx == W_SECS || idx == W_FRAC_HI || idx == W_FRAC_LO) ? S_TIME :
               idx == W_MSG ? S_MSG :
               idx == W_SEQ ? S_SEQ : S_DRAIN;
    endfunction

endpackage

// File: rtl/vita_tx_flow_ctrl_if.sv
// vita_tx_flow_ctrl_if: 36-bit packet stream ([32]=SOF, [33]=EOF) with src/dst ready handshake.
interface vita_tx_flow_ctrl_if;
    logic [35:0] data;
    logic        src_rdy;
    logic        dst_rdy;
    modport master (output data, output src_rdy, input dst_rdy);
    modport slave  (input data, input src_rdy, output dst_rdy);
endinterface

// File: rtl/vita_tx_flow_ctrl_parser.sv
// vita_ctx_parser: walks context packets word by word and flags, at EOF, whether the
// packet was complete and addressed to our streamid.
module vita_ctx_parser
    import vita_tx_flow_ctrl_pkg::*;
#(
    parameter bit USE_TRANS_HEADER = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [31:0]      streamid,
    input  logic [33:0]      data,
    input  logic             vld,
    output logic             good,
    output logic             strobe,
    output logic [31:0]      message,
    output logic [SEQ_W-1:0] seqnum,
    output ctx_state_t       state
);

    ctx_state_t       role, state_n;
    logic [2:0]       idx, idx_n, cur_idx;
    logic             bad, bad_n, sof, eof;
    logic [SEQ_W-1:0] seq_q;

    assign sof = data[32];
    assign eof = data[33];

    // role is what the current word is; an SOF always restarts the packet.
    always_comb begin
        role    = sof ? (USE_TRANS_HEADER ? S_TRANS : S_HDR) : state;
        cur_idx = role == S_HDR ? W_HDR : idx;
        idx_n   = role == S_TRANS ? W_HDR : cur_idx + {2'b00, cur_idx != 3'd7};
        bad_n   = (sof ? 1'b0 : bad) | (role == S_SID && data[31:0] != streamid);
        state_n = state;
        if (vld)
            state_n = (eof || role == S_IDLE) ? S_IDLE : word_state(idx_n);
        strobe  = vld & eof & (role != S_IDLE);
        good    = ~bad_n & (role == S_SEQ || role == S_DRAIN);
        seqnum  = role == S_SEQ ? data[SEQ_W-1:0] : seq_q;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= clr ? S_IDLE : state_n;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            idx     <= W_HDR;
            bad     <= 1'b0;
            message <= '0;
            seq_q   <= '0;
        end else if (clr) begin
            idx <= W_HDR;
            bad <= 1'b0;
        end else if (vld) begin
            idx <= idx_n;
            bad <= bad_n;
            if (role == S_MSG) message <= data[31:0];
            if (role == S_SEQ) seq_q <= data[SEQ_W-1:0];
        end

endmodule

// File: rtl/vita_tx_flow_ctrl.sv
// vita_tx_flow_ctrl: decodes flow-ack / error context packets from the TX chain and
// holds outbound packets at SOF so at most `window` packets are unacknowledged.
module vita_tx_flow_ctrl
    import vita_tx_flow_ctrl_pkg::*;
#(
    parameter int BASE             = 0,
    parameter bit USE_TRANS_HEADER = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set_stb,
    input  logic [7:0]          set_addr,
    input  logic [31:0]         set_data,
    vita_tx_flow_ctrl_if.slave  ctx,
    vita_tx_flow_ctrl_if.slave  tx_in,
    vita_tx_flow_ctrl_if.master tx_out,
    output logic                err_stb,
    output logic [31:0]         err_code,
    output logic [SEQ_W-1:0]    err_seqnum,
    output logic [SEQ_W-1:0]    acked_seqnum,
    output logic [SEQ_W:0]      in_flight,
    output logic                stalled,
    output logic [31:0]         debug
);

    logic [SEQ_W-1:0] window, sent_seq, p_seqnum;
    logic [31:0]      streamid, p_message;
    logic             p_good, p_strobe, in_pkt, open, tx_acc, tx_eof;
    logic             wr_win, wr_sid, clr_cnt, report, unused_ok;
    ctx_state_t       p_state;

    assign wr_win  = set_stb && set_addr == 8'(BASE) + SR_WINDOW;
    assign wr_sid  = set_stb && set_addr == 8'(BASE) + SR_STREAMID;
    assign clr_cnt = wr_sid || (set_stb && set_addr == 8'(BASE) + SR_CLEAR);
    // A streamid write resets the parser, so a report finishing that cycle is dropped.
    assign report  = p_strobe & p_good & ~wr_sid;

    assign in_flight = {1'b0, sent_seq - acked_seqnum};
    assign open      = in_pkt || window == '0 || in_flight < {1'b0, window};
    assign tx_eof    = tx_in.data[33];
    assign tx_acc    = tx_in.src_rdy & tx_out.dst_rdy & open;
    assign stalled   = tx_in.src_rdy & ~in_pkt & ~open;

    assign tx_out.data    = tx_in.data;
    assign tx_out.src_rdy = tx_in.src_rdy & open;
    assign tx_in.dst_rdy  = tx_out.dst_rdy & open;
    assign ctx.dst_rdy    = 1'b1;
    assign unused_ok      = ^ctx.data[35:34];

    assign debug = {p_state, in_flight, sent_seq, in_pkt, open, err_stb, window == '0};

    vita_ctx_parser #(.USE_TRANS_HEADER(USE_TRANS_HEADER)) u_parser (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (wr_sid),
        .streamid (streamid),
        .data     (ctx.data[33:0]),
        .vld      (ctx.src_rdy),
        .good     (p_good),
        .strobe   (p_strobe),
        .message  (p_message),
        .seqnum   (p_seqnum),
        .state    (p_state)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            window   <= '0;
            streamid <= '0;
        end else begin
            if (wr_win) window <= set_data[SEQ_W-1:0];
            if (wr_sid) streamid <= set_data;
        end

    // in_pkt survives counter clears so an in-progress packet is never cut.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            in_pkt       <= 1'b0;
            sent_seq     <= '0;
            acked_seqnum <= '0;
        end else begin
            if (tx_acc) in_pkt <= ~tx_eof;
            sent_seq     <= clr_cnt ? '0 : sent_seq + {{SEQ_W-1{1'b0}}, tx_acc & tx_eof};
            acked_seqnum <= clr_cnt ? '0 : (report && p_message == '0) ? p_seqnum : acked_seqnum;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            err_stb    <= 1'b0;
            err_code   <= '0;
            err_seqnum <= '0;
        end else begin
            err_stb <= report && p_message != '0;
            if (report && p_message != '0) begin
                err_code   <= p_message;
                err_seqnum <= p_seqnum;
            end
        end

endmodule
